// File: rtl/stage_sequencer.sv
// Game-progress controller for the stage LED bar: counts cleared stages and lives,
// paces rounds with a result pause, and blinks all lamps on victory.
module stage_sequencer #(
   parameter int SHOW_CYCLES = 50_000_000,
   parameter int BLINK_HALF  = 12_500_000,
   parameter int LIVES       = 3,
   parameter int TIMER_W     = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       round_win,
   input  logic       round_lose,
   output logic       round_go,
   output logic       light1,
   output logic       light2,
   output logic       light3,
   output logic [1:0] stage,
   output logic [1:0] lives,
   output logic       victory,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE, PLAY, PASS_SHOW, FAIL_SHOW, VICTORY, GAME_OVER
   } state_t;

   localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] BLINK_LAST = TIMER_W'(BLINK_HALF - 1);
   localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

   state_t             state, state_n;
   logic [1:0]         stage_n, lives_n;
   logic [TIMER_W-1:0] timer, timer_n;
   logic               phase, phase_n;
   logic [2:0]         lamps_n;

   always_comb begin
      state_n = state;
      stage_n = stage;
      lives_n = lives;
      timer_n = timer;
      phase_n = phase;
      unique case (state)
         IDLE, VICTORY, GAME_OVER: begin
            if (start) begin
               state_n = PLAY;
               stage_n = 2'd0;
               lives_n = LIVES_INIT;
               timer_n = '0;
               phase_n = 1'b0;
            end else if (state == VICTORY) begin
               if (timer == BLINK_LAST) begin
                  timer_n = '0;
                  phase_n = ~phase;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
         end
         PLAY: begin
            // a simultaneous win and lose counts as a lose
            if (round_lose) begin
               lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
               state_n = (lives_n == 2'd0) ? GAME_OVER : FAIL_SHOW;
               timer_n = '0;
            end else if (round_win) begin
               stage_n = (stage != 2'd3) ? stage + 2'd1 : 2'd3;
               state_n = (stage_n == 2'd3) ? VICTORY : PASS_SHOW;
               timer_n = '0;
               phase_n = 1'b1;
            end
         end
         PASS_SHOW, FAIL_SHOW: begin
            if (timer == SHOW_LAST) begin
               state_n = PLAY;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n == VICTORY)
         lamps_n = {3{phase_n}};
      else
         lamps_n = {stage_n == 2'd3, stage_n >= 2'd2, stage_n >= 2'd1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stage     <= 2'd0;
         lives     <= LIVES_INIT;
         timer     <= '0;
         phase     <= 1'b0;
         round_go  <= 1'b0;
         light1    <= 1'b0;
         light2    <= 1'b0;
         light3    <= 1'b0;
         victory   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         stage     <= stage_n;
         lives     <= lives_n;
         timer     <= timer_n;
         phase     <= phase_n;
         round_go  <= (state_n == PLAY) && (state != PLAY);
         light1    <= lamps_n[0];
         light2    <= lamps_n[1];
         light3    <= lamps_n[2];
         victory   <= (state_n == VICTORY);
         game_over <= (state_n == GAME_OVER);
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a mode/countdown reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_stage_sequencer;

  localparam int SHOW  = 4;
  localparam int BLINK = 2;
  localparam int NLIV  = 2;

  localparam int M_IDLE = 0, M_PLAY = 1, M_SHOW = 2, M_VIC = 3, M_OVER = 4;

  typedef struct packed {
    logic [1:0] stage;
    logic [1:0] lives;
    logic [2:0] lamps;
    logic       go;
    logic       vic;
    logic       over;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       round_win = 1'b0;
  logic       round_lose = 1'b0;
  logic       round_go;
  logic       light1, light2, light3;
  logic [1:0] stage;
  logic [1:0] lives;
  logic       victory, game_over;

  int errors = 0;
  int checks = 0;
  obs_t q[$];

  int m_mode, m_stage, m_lives, m_pause, m_blink, m_phase, m_go;

  stage_sequencer #(
    .SHOW_CYCLES(SHOW), .BLINK_HALF(BLINK),
    .LIVES(NLIV), .TIMER_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .round_win(round_win), .round_lose(round_lose),
    .round_go(round_go), .light1(light1),
    .light2(light2), .light3(light3),
    .stage(stage), .lives(lives),
    .victory(victory), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic obs_t predict();
    obs_t o;
    o.stage = 2'(m_stage);
    o.lives = 2'(m_lives);
    if (m_mode == M_VIC)
      o.lamps = (m_phase != 0) ? 3'b111 : 3'b000;
    else
      o.lamps = 3'((1 << m_stage) - 1);
    o.go   = (m_go != 0);
    o.vic  = (m_mode == M_VIC);
    o.over = (m_mode == M_OVER);
    return o;
  endfunction

  task automatic check1(input string n,
                        input logic got,
                        input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b",
               n, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_stage = 0; m_lives = NLIV;
    m_pause = 0; m_blink = 0; m_phase = 0; m_go = 0;
  endtask

  task automatic model_step(input logic s,
                            input logic w,
                            input logic l);
    m_go = 0;
    case (m_mode)
      M_IDLE, M_VIC, M_OVER: begin
        if (s) begin
          m_mode = M_PLAY; m_stage = 0;
          m_lives = NLIV; m_go = 1;
        end else if (m_mode == M_VIC) begin
          m_blink++;
          if (m_blink == BLINK) begin
            m_blink = 0;
            m_phase = 1 - m_phase;
          end
        end
      end
      M_PLAY: begin
        if (l) begin
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_mode = M_SHOW; m_pause = SHOW; end
        end else if (w) begin
          if (m_stage < 3) m_stage++;
          if (m_stage == 3) begin
            m_mode = M_VIC; m_blink = 0; m_phase = 1;
          end else begin
            m_mode = M_SHOW; m_pause = SHOW;
          end
        end
      end
      default: begin
        m_pause--;
        if (m_pause == 0) begin m_mode = M_PLAY; m_go = 1; end
      end
    endcase
  endtask

  task automatic step(input logic r, input logic s,
                      input logic w, input logic l);
    @(posedge clk);
    #1;
    rst_n = r; start = s; round_win = w; round_lose = l;
    if (!r) begin
      model_reset();
      q.delete();
      q.push_back(predict());
      q.push_back(predict());
    end else begin
      model_step(s, w, l);
      q.push_back(predict());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    obs_t act, exp_o;
    if (q.size() > 0) begin
      exp_o = q.pop_front();
      act = '{stage, lives, {light3, light2, light1},
              round_go, victory, game_over};
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL outputs t=%0t got stage=%0d lives=%0d lamps=%b go=%b vic=%b over=%b want stage=%0d lives=%0d lamps=%b go=%b vic=%b over=%b",
                 $time, act.stage, act.lives, act.lamps,
                 act.go, act.vic, act.over,
                 exp_o.stage, exp_o.lives, exp_o.lamps,
                 exp_o.go, exp_o.vic, exp_o.over);
      end
    end
  end

  initial begin
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check1("reset state",
           (stage == 2'd0) && (lives == 2'(NLIV)) &&
           !light1 && !light2 && !light3 &&
           !round_go && !victory && !game_over,
           1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check1("go before wait", round_go, 1'b0);
    idle(1);
    check1("go after wait", round_go, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 4000; i++) begin
      logic r, s, w, l;
      r = ($urandom_range(0, 399) != 0);
      s = ($urandom_range(0, 14) == 0);
      w = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 11) == 0);
      step(r, s, w, l);
    end
    idle(3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
